// File: rtl/priority_arbiter.sv
// N-requester arbiter with a registered, held grant: fixed-priority or round-robin
// selection, owner-driven release via done, and an optional forced release after MAX_HOLD cycles.
module priority_arbiter #(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 16,
    localparam int IDXW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            mode,
    input  logic            done,
    output logic            none,
    output logic            gnt_valid,
    output logic [IDXW-1:0] gnt_idx,
    output logic [N-1:0]    gnt_onehot,
    output logic            timeout
);

    localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HCW-1:0]  HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
    localparam logic [IDXW:0]   N_EXT     = (IDXW + 1)'(N);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state,      w_state_nxt;
    logic [IDXW-1:0] r_gnt_idx,    w_gnt_idx_nxt;
    logic [IDXW-1:0] r_rr_ptr,     w_rr_ptr_nxt;
    logic [N-1:0]    r_gnt_onehot, w_gnt_onehot_nxt;
    logic [HCW-1:0]  r_hold_cnt,   w_hold_cnt_nxt;
    logic            r_timeout;

    logic            w_expire;
    logic            w_release;
    logic            w_arbitrate;
    logic [N-1:0]    w_cand;
    logic            w_any;
    logic [IDXW-1:0] w_fixed_win;
    logic [2*N-1:0]  w_cand_dbl;
    logic [N-1:0]    w_cand_rot;
    logic [IDXW-1:0] w_rr_off;
    logic [IDXW:0]   w_rr_sum;
    logic [IDXW-1:0] w_rr_win;
    logic [IDXW-1:0] w_winner;
    logic [IDXW:0]   w_winner_inc;

    assign none       = (req == '0);
    assign gnt_valid  = (r_state == ST_GRANT);
    assign gnt_idx    = r_gnt_idx;
    assign gnt_onehot = r_gnt_onehot;
    assign timeout    = r_timeout;

    assign w_expire    = (MAX_HOLD != 0) && (r_state == ST_GRANT) && (r_hold_cnt == HOLD_LAST);
    assign w_release   = (r_state == ST_GRANT) && (done || !req[r_gnt_idx] || w_expire);
    assign w_arbitrate = (r_state == ST_IDLE) || w_release;

    // The holder's one-hot doubles as the exclusion mask for a forced release.
    assign w_cand = req & ~(w_expire ? r_gnt_onehot : '0);
    assign w_any  = |w_cand;

    always_comb begin
        w_fixed_win = '0;
        for (int i = 0; i < N; i++) begin
            if (w_cand[i]) w_fixed_win = IDXW'(i);
        end
    end

    // Rotate so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    assign w_cand_dbl = {w_cand, w_cand} >> r_rr_ptr;
    assign w_cand_rot = w_cand_dbl[N-1:0];

    always_comb begin
        w_rr_off = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_cand_rot[j]) w_rr_off = IDXW'(j);
        end
    end

    assign w_rr_sum = {1'b0, r_rr_ptr} + {1'b0, w_rr_off};
    assign w_rr_win = (w_rr_sum >= N_EXT) ? IDXW'(w_rr_sum - N_EXT) : IDXW'(w_rr_sum);

    assign w_winner     = mode ? w_rr_win : w_fixed_win;
    assign w_winner_inc = {1'b0, w_winner} + (IDXW + 1)'(1);

    always_comb begin
        // NOTE: every output of this block is given a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_gnt_idx_nxt    = r_gnt_idx;
        w_gnt_onehot_nxt = r_gnt_onehot;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_rr_ptr_nxt     = r_rr_ptr;

        if (w_arbitrate) begin
            if (w_any) begin
                w_state_nxt      = ST_GRANT;
                w_gnt_idx_nxt    = w_winner;
                w_gnt_onehot_nxt = N'(1) << w_winner;
                w_hold_cnt_nxt   = '0;
                w_rr_ptr_nxt     = (w_winner_inc == N_EXT) ? '0 : IDXW'(w_winner_inc);
            end else begin
                w_state_nxt      = ST_IDLE;
                w_gnt_idx_nxt    = '0;
                w_gnt_onehot_nxt = '0;
            end
        end else if (r_hold_cnt != '1) begin
            w_hold_cnt_nxt = r_hold_cnt + HCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            r_state      <= ST_IDLE;
            r_gnt_idx    <= '0;
            r_gnt_onehot <= '0;
            r_hold_cnt   <= '0;
            r_rr_ptr     <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt_idx    <= w_gnt_idx_nxt;
            r_gnt_onehot <= w_gnt_onehot_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_timeout    <= w_expire;
        end
    end

endmodule
